// File: rtl/iic_write_arbiter.sv
// Round-robin arbiter feeding single-register writes from two requesters into the I2C engine.
// Optional NACK retry is compiled in with `define IIC_WRITE_ARBITER_RETRY_EN.
module iic_write_arbiter #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h76,
    parameter int unsigned GAP_CYCLES = 3000,
    parameter int unsigned GAP_MSB    = 11,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_reg,
    input  logic [7:0] req0_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_reg,
    input  logic [7:0] req1_data,
    output logic       eng_start,
    output logic [6:0] eng_slave,
    output logic [7:0] eng_reg,
    output logic [7:0] eng_data,
    input  logic       eng_done,
    input  logic       eng_nack,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic       rsp_err,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitEng, StGap} state_e;

    localparam int unsigned GAP_LAST = GAP_CYCLES - 1;

    state_e           state_q;
    logic             last_grant_q;
    logic             cmd_id_q;
    logic             retry_pend_q;
    logic [GAP_MSB:0] gap_cnt_q;
    logic             grant;
    logic             idle_ok;
    logic             accept;
    logic             retry_ok;

`ifdef IIC_WRITE_ARBITER_RETRY_EN
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] retry_cnt_q;
    assign retry_ok = eng_nack && (32'(retry_cnt_q) < MAX_RETRY);
`else
    logic unused_max_retry;
    assign unused_max_retry = ^MAX_RETRY;
    assign retry_ok = 1'b0;
`endif

    // On a tie the requester not served last wins; otherwise whoever is valid.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
    end

    assign idle_ok    = (state_q == StIdle) && Reset_n;
    assign req0_ready = idle_ok && req0_valid && !grant;
    assign req1_ready = idle_ok && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign eng_slave  = SLAVE_ADDR;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            cmd_id_q     <= 1'b0;
            retry_pend_q <= 1'b0;
            gap_cnt_q    <= '0;
            eng_start    <= 1'b0;
            eng_reg      <= 8'h00;
            eng_data     <= 8'h00;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
`ifdef IIC_WRITE_ARBITER_RETRY_EN
            retry_cnt_q  <= '0;
`endif
        end else begin
            eng_start <= 1'b0;
            rsp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        cmd_id_q     <= grant;
                        last_grant_q <= grant;
                        eng_reg      <= grant ? req1_reg : req0_reg;
                        eng_data     <= grant ? req1_data : req0_data;
                        retry_pend_q <= 1'b0;
`ifdef IIC_WRITE_ARBITER_RETRY_EN
                        retry_cnt_q  <= '0;
`endif
                        eng_start    <= 1'b1;
                        busy         <= 1'b1;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
                    state_q <= StWaitEng;
                end
                StWaitEng: begin
                    if (eng_done) begin
                        gap_cnt_q <= '0;
                        state_q   <= StGap;
                        if (retry_ok) begin
                            retry_pend_q <= 1'b1;
`ifdef IIC_WRITE_ARBITER_RETRY_EN
                            retry_cnt_q  <= retry_cnt_q + 1'b1;
`endif
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_id    <= cmd_id_q;
                            rsp_err   <= eng_nack;
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GAP_LAST[GAP_MSB:0]) begin
                        gap_cnt_q <= '0;
                        if (retry_pend_q) begin
                            // Re-issue the latched command; cmd registers are untouched.
                            retry_pend_q <= 1'b0;
                            eng_start    <= 1'b1;
                            state_q      <= StIssue;
                        end else begin
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iic_write_arbiter.sv
// Bench for iic_write_arbiter: event-time reference model checked every cycle, plus directed
// literal checks. Expectations follow IIC_WRITE_ARBITER_RETRY_EN when it is defined.
module tb_iic_write_arbiter;

    localparam int unsigned GAP     = 12;
    localparam int unsigned ENG_LAT = 3;
    localparam int unsigned MAXR    = 3;
`ifdef IIC_WRITE_ARBITER_RETRY_EN
    localparam int unsigned ALLOWED = MAXR;
`else
    localparam int unsigned ALLOWED = 0;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_reg = 8'h00, req0_data = 8'h00, req1_reg = 8'h00, req1_data = 8'h00;
    logic       eng_done = 1'b0, eng_nack = 1'b0;
    logic       req0_ready, req1_ready, eng_start, rsp_valid, rsp_id, rsp_err, busy;
    logic [6:0] eng_slave;
    logic [7:0] eng_reg, eng_data;

    iic_write_arbiter #(
        .SLAVE_ADDR (7'h76),
        .GAP_CYCLES (GAP),
        .GAP_MSB    (11),
        .MAX_RETRY  (MAXR)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_reg   (req0_reg),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_reg   (req1_reg),
        .req1_data  (req1_data),
        .eng_start  (eng_start),
        .eng_slave  (eng_slave),
        .eng_reg    (eng_reg),
        .eng_data   (eng_data),
        .eng_done   (eng_done),
        .eng_nack   (eng_nack),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    longint cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
    endtask

    // Reference model: each command is a set of predicted event times.
    bit         m_known = 0, m_idle = 1, m_wait = 0, m_last = 1, m_id = 0, m_err = 0;
    longint     m_start_at = -1, m_rsp_at = -1, m_idle_at = -1;
    logic [7:0] m_reg = 8'h00, m_data = 8'h00;
    int         m_tries = 0;

    // Observations for directed checks.
    int         n_start = 0, n_rsp = 0;
    logic       last_rsp_id, last_rsp_err;
    logic [7:0] st_reg, st_data;
    logic [6:0] st_slave;
    longint     last_rsp_cyc = -1;
    int         acc_ids[$];
    longint     acc_cyc[$];
    longint     start_cyc[$];
    longint     rsp_cyc[$];

    always @(negedge Clk) begin
        bit g, e0, e1, st, rv;
        if (!Reset_n) begin
            if (m_known) begin
                chk("req0_ready_in_reset", req0_ready, 0);
                chk("req1_ready_in_reset", req1_ready, 0);
            end
            m_known = 1; m_idle = 1; m_wait = 0; m_last = 1; m_id = 0; m_err = 0;
            m_start_at = -1; m_rsp_at = -1; m_idle_at = -1;
            m_reg = 8'h00; m_data = 8'h00; m_tries = 0; last_rsp_cyc = -1;
        end else if (m_known) begin
            if (cyc == m_idle_at) m_idle = 1;
            g  = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e0 = m_idle && req0_valid && !g;
            e1 = m_idle && req1_valid && g;
            st = (cyc == m_start_at);
            rv = (cyc == m_rsp_at);
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            chk("eng_start", eng_start, st);
            chk("rsp_valid", rsp_valid, rv);
            chk("busy", busy, !m_idle);
            chk("eng_reg", eng_reg, m_reg);
            chk("eng_data", eng_data, m_data);
            chk("eng_slave", eng_slave, 7'h76);
            if (rv) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_err", rsp_err, m_err);
            end

            if (eng_start === 1'b1) begin
                n_start++;
                st_reg = eng_reg; st_data = eng_data; st_slave = eng_slave;
                start_cyc.push_back(cyc);
            end
            if (rsp_valid === 1'b1) begin
                n_rsp++;
                last_rsp_id = rsp_id; last_rsp_err = rsp_err; last_rsp_cyc = cyc;
                rsp_cyc.push_back(cyc);
            end
            if ((req0_valid && req0_ready === 1'b1) || (req1_valid && req1_ready === 1'b1)) begin
                acc_ids.push_back(req1_ready === 1'b1 ? 1 : 0);
                acc_cyc.push_back(cyc);
                if (last_rsp_cyc >= 0) chk("accept_after_gap", (cyc - last_rsp_cyc) >= GAP, 1);
            end

            if (m_wait && eng_done) begin
                m_wait = 0;
                if (eng_nack && m_tries < int'(ALLOWED)) begin
                    m_tries++;
                    m_start_at = cyc + 1 + GAP;
                end else begin
                    m_rsp_at  = cyc + 1;
                    m_err     = eng_nack;
                    m_idle_at = cyc + 1 + GAP;
                end
            end
            if (st) m_wait = 1;
            if (e0 || e1) begin
                m_idle = 0; m_id = g; m_last = g;
                m_reg  = g ? req1_reg : req0_reg;
                m_data = g ? req1_data : req0_data;
                m_tries = 0; m_start_at = cyc + 1; m_idle_at = -1;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
    endtask

    task automatic send(input bit id, input logic [7:0] r, input logic [7:0] d);
        int n = 0;
        if (id) begin req1_valid = 1'b1; req1_reg = r; req1_data = d; end
        else    begin req0_valid = 1'b1; req0_reg = r; req0_data = d; end
        @(negedge Clk);
        while ((id ? req1_ready : req0_ready) !== 1'b1 && n < 500) begin
            @(negedge Clk);
            n++;
        end
        if ((id ? req1_ready : req0_ready) !== 1'b1) timeout_fail("send_ready");
        @(posedge Clk);
        #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        @(negedge Clk);
        while (eng_start !== 1'b1 && n < 500) begin
            @(negedge Clk);
            n++;
        end
        if (eng_start !== 1'b1) timeout_fail("eng_start");
    endtask

    task automatic serve(input bit nack);
        wait_start();
        repeat (ENG_LAT) @(posedge Clk);
        #1;
        eng_done = 1'b1;
        eng_nack = nack;
        tick();
        eng_done = 1'b0;
        eng_nack = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge Clk);
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        if (busy !== 1'b0) timeout_fail("wait_idle");
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0;
        longint t0;

        // Reset values
        do_reset();
        @(negedge Clk);
        chk("rst_busy", busy, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_eng_reg", eng_reg, 8'h00);
        chk("rst_eng_data", eng_data, 8'h00);
        tick();

        // Single write from requester 0
        acc_cyc.delete(); start_cyc.delete(); rsp_cyc.delete();
        t0 = cyc;
        fork
            send(0, 8'h49, 8'hC0);
            serve(0);
        join
        wait_idle();
        chk("t1_accept_cycle", 32'(acc_cyc[0] - t0), 0);
        chk("t1_start_latency", 32'(start_cyc[0] - acc_cyc[0]), 1);
        chk("t1_eng_reg", st_reg, 8'h49);
        chk("t1_eng_data", st_data, 8'hC0);
        chk("t1_eng_slave", st_slave, 7'h76);
        chk("t1_rsp_latency", 32'(rsp_cyc[0] - start_cyc[0]), ENG_LAT + 1);
        chk("t1_rsp_id", last_rsp_id, 0);
        chk("t1_rsp_err", last_rsp_err, 0);
        chk("t1_rsp_count", n_rsp, 1);

        // Both requesters contending: grants alternate starting with requester 0
        do_reset();
        acc_ids.delete(); acc_cyc.delete();
        fork
            begin send(0, 8'h10, 8'h01); send(0, 8'h11, 8'h02); end
            begin send(1, 8'h20, 8'h03); send(1, 8'h21, 8'h04); end
            repeat (4) serve(0);
        join
        wait_idle();
        chk("t2_accepts", acc_ids.size(), 4);
        for (int i = 0; i < acc_ids.size(); i++) chk("t2_grant_order", acc_ids[i], i % 2);
        for (int i = 1; i < acc_cyc.size(); i++)
            chk("t2_accept_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), ENG_LAT + GAP + 2);

        // NACK on every attempt
        s0 = n_start; r0 = n_rsp; start_cyc.delete();
        fork
            send(1, 8'h30, 8'h33);
            repeat (ALLOWED + 1) serve(1);
        join
        wait_idle();
        chk("t3_start_count", n_start - s0, ALLOWED + 1);
        chk("t3_rsp_count", n_rsp - r0, 1);
        chk("t3_rsp_err", last_rsp_err, 1);
        chk("t3_rsp_id", last_rsp_id, 1);
        for (int i = 1; i < start_cyc.size(); i++)
            chk("t3_retry_spacing", 32'(start_cyc[i] - start_cyc[i-1]), ENG_LAT + GAP + 1);

        // NACK then ACK
        s0 = n_start; r0 = n_rsp;
        fork
            send(0, 8'h40, 8'h44);
            begin serve(1); if (ALLOWED > 0) serve(0); end
        join
        wait_idle();
        chk("t4_start_count", n_start - s0, (ALLOWED > 0) ? 2 : 1);
        chk("t4_rsp_count", n_rsp - r0, 1);
        chk("t4_rsp_err", last_rsp_err, (ALLOWED > 0) ? 0 : 1);

        // Reset while waiting on the engine
        r0 = n_rsp;
        fork
            send(0, 8'h50, 8'h55);
            wait_start();
        join
        tick();
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("t5_busy_after_reset", busy, 0);
        chk("t5_eng_reg_after_reset", eng_reg, 8'h00);
        repeat (GAP + 8) tick();
        chk("t5_no_rsp", n_rsp - r0, 0);
        acc_ids.delete();
        fork
            send(0, 8'h51, 8'h5A);
            send(1, 8'h61, 8'h6A);
            repeat (2) serve(0);
        join
        wait_idle();
        chk("t5_first_grant", acc_ids[0], 0);
        chk("t5_second_grant", acc_ids[1], 1);

        // Spurious eng_done in GAP and in IDLE
        r0 = n_rsp;
        fork
            send(1, 8'h70, 8'h77);
            serve(0);
        join
        repeat (3) tick();
        eng_done = 1'b1; eng_nack = 1'b1;
        tick();
        eng_done = 1'b0; eng_nack = 1'b0;
        wait_idle();
        s0 = n_start;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        repeat (4) tick();
        @(negedge Clk);
        chk("t6_rsp_count", n_rsp - r0, 1);
        chk("t6_no_start", n_start - s0, 0);
        chk("t6_busy", busy, 0);
        chk("t6_rsp_err", last_rsp_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
